// File: rtl/data_memory_arbiter_pkg.sv
// Purpose: shared state encoding and requester IDs for the data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_memory_arbiter_pkg;

  // Arbiter FSM encoding: one idle state plus one serve state per requester.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arbState_t;

  // Requester identifiers, used as the round-robin priority pointer value.
  localparam logic REQ_ID_A = 1'b0;
  localparam logic REQ_ID_B = 1'b1;

endpackage

// File: rtl/data_memory_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port data memory between CPU (A) and IO/DMA (B).
// Latency: request sampled at edge N -> Ack in cycle N..N+1 -> RdValid/ReadData in cycle N+1..N+2.
// Backpressure: a requester holds ReqX until it sees AckX; a losing requester simply waits.
//
// Ports:
//   clk, reset                 clock (rising edge) and asynchronous active-low reset
//   ReqX, WriteX               request and store(1)/load(0) select from requester X
//   AddressX, WriteDataX       byte address and store data from requester X
//   AckX                       high for the one cycle X owns the memory
//   ReadDataX, RdValidX        registered load result and its one-cycle valid pulse
//   MemAddress, MemWriteData   address/data to the memory, from the latched winner
//   MemWrite, MemRead          memory strobes, only while serving
//   MemReadData                combinational read data from the memory
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ReqA,
  input  logic                  ReqB,
  input  logic                  WriteA,
  input  logic                  WriteB,
  input  logic [DATA_WIDTH-1:0] AddressA,
  input  logic [DATA_WIDTH-1:0] AddressB,
  input  logic [DATA_WIDTH-1:0] WriteDataA,
  input  logic [DATA_WIDTH-1:0] WriteDataB,
  output logic                  AckA,
  output logic                  AckB,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  output logic                  RdValidA,
  output logic                  RdValidB,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  arbState_t             state;
  arbState_t             nextState;
  logic                  lastServed;
  logic [DATA_WIDTH-1:0] addrLat;
  logic [DATA_WIDTH-1:0] wdataLat;
  logic                  writeLat;
  logic                  serving;

  // Grant decision is made at every edge, including the one ending a serve
  // cycle, so a requester that keeps ReqX high gets a back-to-back slot and
  // contention alternates with no idle bubble.
  always_comb begin
    nextState = IDLE;
    if (ReqA && ReqB) begin
      nextState = (lastServed == REQ_ID_A) ? SERVE_B : SERVE_A;
    end else if (ReqA) begin
      nextState = SERVE_A;
    end else if (ReqB) begin
      nextState = SERVE_B;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lastServed <= REQ_ID_B;  // A wins the first tie
      addrLat    <= '0;
      wdataLat   <= '0;
      writeLat   <= 1'b0;
      ReadDataA  <= '0;
      ReadDataB  <= '0;
      RdValidA   <= 1'b0;
      RdValidB   <= 1'b0;
    end else begin
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;

      // Completing a load: the memory output is valid for the latched address
      // during the serve cycle, so capture it on the edge that ends it.
      if (state == SERVE_A && !writeLat) begin
        ReadDataA <= MemReadData;
        RdValidA  <= 1'b1;
      end
      if (state == SERVE_B && !writeLat) begin
        ReadDataB <= MemReadData;
        RdValidB  <= 1'b1;
      end

      state <= nextState;

      // Request-side inputs are only looked at here; during the serve cycle
      // the memory is driven purely from these latched copies.
      case (nextState)
        SERVE_A: begin
          lastServed <= REQ_ID_A;
          addrLat    <= AddressA;
          wdataLat   <= WriteDataA;
          writeLat   <= WriteA;
        end
        SERVE_B: begin
          lastServed <= REQ_ID_B;
          addrLat    <= AddressB;
          wdataLat   <= WriteDataB;
          writeLat   <= WriteB;
        end
        default: begin
        end
      endcase
    end
  end

  assign serving      = (state == SERVE_A) || (state == SERVE_B);
  assign AckA         = (state == SERVE_A);
  assign AckB         = (state == SERVE_B);
  assign MemAddress   = addrLat;
  assign MemWriteData = wdataLat;
  assign MemWrite     = serving && writeLat;
  assign MemRead      = serving && !writeLat;

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data and byte-address width of every data/address port.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ReqA/ReqB  input  1  transaction request from requester A (CPU) / B (IO/DMA).
REQ-005 SHALL have ports WriteA/WriteB  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports AddressA/AddressB, WriteDataA/WriteDataB  input  DATA_WIDTH  byte address / store data.
REQ-007 SHALL have ports AckA/AckB  output  1  high for exactly the cycle the requester's transaction owns the memory.
REQ-008 SHALL have ports ReadDataA/ReadDataB  output  DATA_WIDTH  registered load result.
REQ-009 SHALL have ports RdValidA/RdValidB  output  1  one-cycle pulse: ReadDataX holds a new load result.
REQ-010 SHALL have ports MemAddress, MemWriteData  output  DATA_WIDTH  and MemWrite, MemRead  output  1  driving the single-port data memory.
REQ-011 SHALL have port MemReadData  input  DATA_WIDTH  combinational read data from the memory.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_A, SERVE_B; AckA = (state==SERVE_A), AckB = (state==SERVE_B).
REQ-013 SHALL, at every edge in any state, pick next state: only ReqA -> SERVE_A; only ReqB -> SERVE_B; neither -> IDLE; both -> requester not indicated by priority pointer LastServed.
REQ-014 SHALL update LastServed to the granted requester on every edge entering SERVE_x (round-robin; no starvation).
REQ-015 SHALL latch the winner's Address, WriteData, Write into internal registers on the edge entering SERVE_x and drive MemAddress/MemWriteData from them during SERVE_x.
REQ-016 SHALL assert MemWrite = latched Write and MemRead = !latched Write only in SERVE_A/SERVE_B; both 0 in IDLE.
REQ-017 SHALL, on the edge ending a SERVE_x load, capture MemReadData into ReadDataX and pulse RdValidX for the following cycle; stores leave ReadDataX unchanged and no RdValidX pulse.
REQ-018 SHALL hold ReadDataX stable between loads; ReadDataA never changes on B transactions and vice versa.
REQ-019 SHALL treat ReqX still high at the edge ending its Ack cycle as a new back-to-back request; requesters drop ReqX within the Ack cycle when done.
REQ-020 SHALL give latency: request seen at edge N -> Ack during cycle N..N+1 -> RdValid/ReadData during cycle N+1..N+2.
REQ-021 SHALL, with both requesting continuously, alternate A,B,A,B with one transaction per cycle (full throughput, no IDLE bubbles).
REQ-022 SHALL ignore request-side input changes during SERVE_x (latched values used).

Reset
REQ-023 SHALL on reset low, immediately: state IDLE, LastServed = B (A wins first tie), AckA/AckB 0, RdValidA/RdValidB 0, ReadDataA/ReadDataB 0, latched address/data/write 0, MemWrite/MemRead 0.
REQ-024 SHALL abort any in-flight transaction on reset mid-SERVE: no write completes after reset asserts, no RdValid pulse.

Structure
REQ-025 SHALL place the state encoding (2-bit, IDLE=0, SERVE_A=1, SERVE_B=2) and requester-ID constants (A=0, B=1) in shared package data_memory_arbiter_pkg.
REQ-026 SHALL contain no sub-module; the round-robin grant logic is a single combinational next-state block inside this module.

Verification (DATA_WIDTH=32, memory 1024 words attached)
REQ-027 SHALL cover single store/load: A writes 0xDEADBEEF @0x10, then A loads 0x10 -> AckA one cycle each, RdValidA pulse, ReadDataA = 0xDEADBEEF, ReadDataB unchanged 0.
REQ-028 SHALL cover simultaneous first request after reset: ReqA and ReqB loads @0x0/@0x4 -> AckA first, AckB next cycle, no gap.
REQ-029 SHALL cover continuous contention: ReqA, ReqB held high 6 cycles -> grant order A,B,A,B,A,B; MemRead high all 6 cycles.
REQ-030 SHALL cover cross isolation: B stores 0x12345678 @0x20, A loads 0x20 next -> ReadDataA = 0x12345678, no RdValidB pulse.
REQ-031 SHALL cover reset mid-operation: reset low during SERVE_B store of 0xCAFEF00D @0x30 after edge -> all outputs 0 immediately, MemWrite 0; after release, load @0x30 returns prior contents.
REQ-032 SHALL cover idle: no requests 10 cycles -> state IDLE, MemRead/MemWrite 0, all Ack/RdValid 0.
